// File: rtl/ram_responder.sv
// ram_responder: word RAM answering the CPU bus, zeroed after every reset, with pipelined reads and sticky error capture
module ram_responder #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] err_addr_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic {CLEAR, READY} state_t;
    state_t        state;
    logic [AW-1:0] clr_ptr;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   pipe [READ_LATENCY];
    logic [31:0]   off;
    logic [31:0]   slot;
    logic [AW-1:0] idx;
    logic          legal;
    always_comb begin
        off   = addr_i - BASE_ADDR;
        idx   = off[AW+1:2];
        legal = addr_i >= BASE_ADDR && off < 32'(DEPTH_WORDS * 4) && addr_i[1:0] == 2'b00;
        slot  = state == READY && legal ? (we_i ? data_i : mem[idx]) : 32'h0;
    end
    assign data_o = pipe[READ_LATENCY-1];
    always_ff @(posedge clk)
        if (!reset) begin
            if (state == CLEAR)
                mem[clr_ptr] <= 32'h0;
            else if (we_i && legal)
                mem[idx] <= data_i;
        end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            clr_ptr    <= '0;
            busy_o     <= 1'b1;
            err_o      <= 1'b0;
            err_addr_o <= 32'h0;
            for (int i = 0; i < READ_LATENCY; i++)
                pipe[i] <= 32'h0;
        end else begin
            pipe[0] <= slot;
            for (int i = 1; i < READ_LATENCY; i++)
                pipe[i] <= pipe[i-1];
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + AW'(1);
                if (&clr_ptr) begin
                    state  <= READY;
                    busy_o <= 1'b0;
                end
            end else if (!legal) begin
                err_o <= 1'b1;
                if (!err_o)
                    err_addr_o <= addr_i;
            end
        end
    end
endmodule
